// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock set-time controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2,
    COMMIT  = 2'd3
  } mode_e;

  localparam int unsigned TIME_MAX = 59;

  typedef logic [5:0] time_t;

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter with enable and synchronous clear; wrap_o pulses on the
// enabled terminal count.
module tick_gen #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/clock_set_controller.sv
// 1 Hz advance enable plus button-driven set-time FSM that issues a one-cycle
// parallel load of the edited minutes/seconds to the counter.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000,
  parameter int unsigned TIME_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [TIME_W-1:0] cur_sec,
  input  logic [TIME_W-1:0] cur_min,
  output logic              tick_en,
  output logic              load,
  output logic [TIME_W-1:0] load_sec,
  output logic [TIME_W-1:0] load_min,
  output logic [1:0]        mode,
  output logic              blink
);

  mode_e             state_q, state_d;
  logic              prev_mode_q, prev_inc_q;
  logic              arm_q;
  logic [TIME_W-1:0] edit_sec_q, edit_sec_d;
  logic [TIME_W-1:0] edit_min_q, edit_min_d;
  logic              blink_q, blink_d;
  logic              mode_evt, inc_evt;
  logic              set_q, set_d, entering;
  logic              run_en, run_clr, blink_clr, blink_wrap;

  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v);
    return (v >= TIME_W'(TIME_MAX)) ? '0 : v + TIME_W'(1);
  endfunction

  // arm_q masks the first cycle after reset so a button held through reset
  // does not register as a fresh press.
  assign mode_evt = arm_q && btn_mode && !prev_mode_q;
  assign inc_evt  = arm_q && btn_inc && !prev_inc_q;

  always_comb begin
    state_d    = state_q;
    edit_sec_d = edit_sec_q;
    edit_min_d = edit_min_q;
    case (state_q)
      RUN: begin
        if (mode_evt) begin
          state_d    = SET_MIN;
          edit_min_d = cur_min;
          edit_sec_d = cur_sec;
        end
      end
      SET_MIN: begin
        if (mode_evt) begin
          state_d = SET_SEC;
        end else if (inc_evt) begin
          edit_min_d = inc_wrap(edit_min_q);
        end
      end
      SET_SEC: begin
        if (mode_evt) begin
          state_d = COMMIT;
        end else if (inc_evt) begin
          edit_sec_d = inc_wrap(edit_sec_q);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Prescaler is cleared whenever the next state leaves RUN so it reads 0
  // throughout the set states and restarts cleanly on return.
  assign run_en  = (state_q == RUN);
  assign run_clr = (state_d != RUN);

  tick_gen #(
    .N(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en_i  (run_en),
    .clr_i (run_clr),
    .wrap_o(tick_en)
  );

  assign set_q     = (state_q == SET_MIN) || (state_q == SET_SEC);
  assign set_d     = (state_d == SET_MIN) || (state_d == SET_SEC);
  assign entering  = set_d && (state_d != state_q);
  assign blink_clr = !set_d || entering;

  tick_gen #(
    .N(BLINK_DIV)
  ) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .en_i  (set_q),
    .clr_i (blink_clr),
    .wrap_o(blink_wrap)
  );

  always_comb begin
    blink_d = 1'b0;
    if (entering) begin
      blink_d = 1'b1;
    end else if (set_d) begin
      blink_d = blink_wrap ? !blink_q : blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      prev_mode_q <= 1'b0;
      prev_inc_q  <= 1'b0;
      arm_q       <= 1'b0;
      edit_sec_q  <= '0;
      edit_min_q  <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_mode_q <= btn_mode;
      prev_inc_q  <= btn_inc;
      arm_q       <= 1'b1;
      edit_sec_q  <= edit_sec_d;
      edit_min_q  <= edit_min_d;
      blink_q     <= blink_d;
    end
  end

  assign load     = (state_q == COMMIT);
  assign load_sec = edit_sec_q;
  assign load_min = edit_min_q;
  assign mode     = state_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with TICK_DIV=4, BLINK_DIV=2.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic [5:0] cur_sec, cur_min;
  logic       tick_en, load, blink;
  logic [5:0] load_sec, load_min;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  clock_set_controller #(
    .TICK_DIV (4),
    .BLINK_DIV(2),
    .TIME_W   (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .cur_sec (cur_sec),
    .cur_min (cur_min),
    .tick_en (tick_en),
    .load    (load),
    .load_sec(load_sec),
    .load_min(load_min),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Button is high for exactly one rising edge; returns at the following negedge.
  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
  endtask

  initial begin
    bit blink_pat[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset    = 1'b1;
    btn_mode = 1'b1;  // held through reset release: must not be seen as a press
    btn_inc  = 1'b0;
    cur_sec  = '0;
    cur_min  = '0;
    repeat (2) @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_tick", tick_en, 0);
    chk("rst_load", load, 0);
    chk("rst_blink", blink, 0);
    chk("rst_lsec", load_sec, 0);
    chk("rst_lmin", load_min, 0);
    reset = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      chk("run_tick", tick_en, (k % 4) == 0);
      chk("run_mode", mode, 0);
      chk("run_load", load, 0);
      chk("run_blink", blink, 0);
      @(negedge clk);
    end
    btn_mode = 1'b0;
    @(negedge clk);

    press_inc();
    chk("run_inc_mode", mode, 0);
    chk("run_inc_lmin", load_min, 0);
    @(negedge clk);

    // Enter SET_MIN capturing 12:34
    cur_min = 6'd12;
    cur_sec = 6'd34;
    press_mode();
    cur_min = 6'd40;
    cur_sec = 6'd41;
    chk("cap_lmin", load_min, 12);
    chk("cap_lsec", load_sec, 34);
    for (int i = 0; i < 5; i++) begin
      chk("setmin_blink", blink, blink_pat[i]);
      chk("setmin_mode", mode, 1);
      chk("setmin_tick", tick_en, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 46; i++) begin
      press_inc();
      @(negedge clk);
    end
    chk("min_58", load_min, 58);
    press_inc();
    chk("min_59", load_min, 59);
    @(negedge clk);
    press_inc();
    chk("min_wrap0", load_min, 0);
    @(negedge clk);
    press_inc();
    chk("min_1", load_min, 1);
    @(negedge clk);

    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    chk("hold_once", load_min, 2);
    chk("hold_mode", mode, 1);

    for (int i = 0; i < 3; i++) begin
      press_inc();
      @(negedge clk);
    end
    chk("min_5", load_min, 5);

    press_mode();
    chk("setsec_mode", mode, 2);
    chk("setsec_blink", blink, 1);
    chk("setsec_lmin", load_min, 5);
    @(negedge clk);
    // 34 -> 59 -> 0 -> 7
    for (int i = 0; i < 33; i++) begin
      press_inc();
      @(negedge clk);
    end
    chk("sec_7", load_sec, 7);
    chk("sec_min_kept", load_min, 5);

    press_mode();
    chk("commit_mode", mode, 3);
    chk("commit_load", load, 1);
    chk("commit_lmin", load_min, 5);
    chk("commit_lsec", load_sec, 7);
    chk("commit_tick", tick_en, 0);
    chk("commit_blink", blink, 0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      chk("post_mode", mode, 0);
      chk("post_load", load, 0);
      chk("post_tick", tick_en, k == 4);
      @(negedge clk);
    end

    // Simultaneous mode/inc in SET_SEC
    cur_min = 6'd10;
    cur_sec = 6'd20;
    press_mode();
    chk("sim_setmin", mode, 1);
    @(negedge clk);
    press_mode();
    chk("sim_setsec", mode, 2);
    @(negedge clk);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    chk("sim_mode", mode, 3);
    chk("sim_load", load, 1);
    chk("sim_lsec", load_sec, 20);
    chk("sim_lmin", load_min, 10);
    @(negedge clk);
    chk("sim_back_run", mode, 0);
    @(negedge clk);

    // Reset while editing seconds
    cur_min = 6'd30;
    cur_sec = 6'd45;
    press_mode();
    @(negedge clk);
    press_mode();
    chk("pre_rst_mode", mode, 2);
    chk("pre_rst_lsec", load_sec, 45);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_lsec", load_sec, 0);
    chk("mrst_lmin", load_min, 0);
    chk("mrst_blink", blink, 0);
    for (int k = 1; k <= 6; k++) begin
      chk("mrst_mode", mode, 0);
      chk("mrst_load", load, 0);
      chk("mrst_tick", tick_en, k == 4);
      @(negedge clk);
    end

    // Out-of-range capture held, first increment wraps to 0
    cur_min = 6'd62;
    cur_sec = 6'd61;
    press_mode();
    chk("oor_lmin", load_min, 62);
    chk("oor_lsec", load_sec, 61);
    @(negedge clk);
    press_inc();
    chk("oor_wrap", load_min, 0);
    chk("oor_sec_kept", load_sec, 61);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequencing and configuration controller for the seconds/minutes counter datapath.
- Generates the 1 Hz advance enable and runs a button-driven set-time state machine (RUN -> SET_MIN -> SET_SEC -> COMMIT).
- Presents a one-cycle parallel load of edited time values to the counter.
- Sits between the user-button synchronizers and the counter.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per tick_en pulse. Minimum 2.
- BLINK_DIV, 12_500_000: clk cycles per blink toggle in set modes. Minimum 1.
- TIME_W, 6: width of the seconds/minutes fields.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  mode button, already synchronized, level
- btn_inc  in  1  increment button, already synchronized, level
- cur_sec  in  TIME_W  current seconds from counter
- cur_min  in  TIME_W  current minutes from counter
- tick_en  out  1  one-cycle advance enable to counter
- load  out  1  one-cycle parallel-load strobe to counter
- load_sec  out  TIME_W  seconds value to load
- load_min  out  TIME_W  minutes value to load
- mode  out  2  current state: RUN=0, SET_MIN=1, SET_SEC=2, COMMIT=3
- blink  out  1  display blink for the field being edited

Behaviour:
- Reset (clk, reset, synchronous, active-high):
  - State goes to RUN.
  - Prescaler, blink counter, edit_sec, edit_min and the button-previous registers all clear to 0.
  - All outputs are 0 on the first cycle after reset.
  - Reset during SET_MIN, SET_SEC or COMMIT discards the edits; no load is issued.
- Edge detect:
  - mode_evt = btn_mode & ~prev_mode; inc_evt = btn_inc & ~prev_inc.
  - prev registers update every cycle.
  - A held button gives exactly one event.
  - A button already high when reset releases gives no event.
- Prescaler, RUN only:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick_en = 1 in the cycle the count equals TICK_DIV-1.
  - Outside RUN the count is held at 0 and tick_en = 0.
  - First tick after entering RUN occurs TICK_DIV cycles after entry.
- FSM transitions, all registered:
  - RUN, mode_evt: capture edit_min <= cur_min and edit_sec <= cur_sec; go to SET_MIN.
  - SET_MIN, mode_evt: go to SET_SEC.
  - SET_MIN, inc_evt: edit_min <= (edit_min >= 59) ? 0 : edit_min+1.
  - SET_SEC, mode_evt: go to COMMIT.
  - SET_SEC, inc_evt: edit_sec increments with the same wrap rule.
  - COMMIT: load = 1 for exactly this one cycle; next state RUN unconditionally. Button events in COMMIT are ignored.
  - inc_evt in RUN is ignored.
- Simultaneous mode_evt and inc_evt: mode_evt wins and inc_evt is dropped. The captured or edited value is unchanged.
- Outputs:
  - load_sec/load_min are driven continuously from edit_sec/edit_min.
  - The counter samples them only when load = 1.
  - mode = state encoding.
- Out-of-range values: a captured cur value > 59 is held as captured. The first increment wraps it to 0.
- Blink:
  - Forced to 0 in RUN and COMMIT.
  - On entry to SET_MIN or SET_SEC, blink = 1 and the blink counter restarts.
  - Toggles every BLINK_DIV cycles while in the set state.
- tick_en and load are never high in the same cycle.

Decomposition:
- Package clock_ctrl_pkg:
  - mode_e enum {RUN, SET_MIN, SET_SEC, COMMIT} as logic [1:0]
  - TIME_MAX = 59
  - time_t = logic [5:0]
- One sub-module, tick_gen: parameterised modulo-N counter with enable and synchronous clear. Instantiated twice, for the prescaler and for blink.

Test Plan (TICK_DIV=4, BLINK_DIV=2):
- Release reset, hold buttons 0 for 12 cycles -> tick_en high on cycles 4, 8, 12 after reset; load, blink and mode all 0.
- cur_min=12, cur_sec=34, pulse btn_mode -> mode=1, tick_en stays 0, load_min=12, load_sec=34; blink pattern 1,1,0,0,1,...
- In SET_MIN with edit_min=58, three btn_inc pulses -> load_min 59, 0, 1. Holding btn_inc high for 10 cycles -> exactly one increment.
- Full cycle: set minutes to 5, seconds to 7, press btn_mode twice -> mode 2 then 3; load=1 for one cycle with load_min=5, load_sec=7; mode=0 next cycle; first tick_en 4 cycles later.
- btn_mode and btn_inc rise in the same cycle while in SET_SEC -> mode goes to 3 and load_sec is unchanged.
- Assert reset while mode=2 -> mode=0, load never asserts, edit registers clear to 0, tick_en resumes after 4 cycles.
